// File: rtl/hs_rx_unpack.sv
// Receive side of a four-phase ready/accepted word handshake. The block captures a wide word and streams it out as lanes.
// Define HS_RX_MSB_FIRST_EN to emit lanes MSB first; the default order is LSB first.
module hs_rx_unpack #(
    parameter int WIDTH_IN    = 64,
    parameter int WIDTH_OUT   = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ready_in,
    input  logic [WIDTH_IN-1:0]  data_in,
    output logic                 accepted,
    output logic [WIDTH_OUT-1:0] out_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_last,
    output logic                 busy
);

    localparam int LANES = WIDTH_IN / WIDTH_OUT;
    localparam int IDX_W = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(LANES - 1);

    generate
        if ((WIDTH_IN % WIDTH_OUT) != 0) begin : g_bad_ratio
            $error("hs_rx_unpack: WIDTH_IN must be a multiple of WIDTH_OUT");
        end
        if (LANES < 2) begin : g_bad_lanes
            $error("hs_rx_unpack: WIDTH_IN/WIDTH_OUT must be at least 2");
        end
        if (SYNC_STAGES < 2) begin : g_bad_sync
            $error("hs_rx_unpack: SYNC_STAGES must be at least 2");
        end
    endgenerate

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACK  = 1'b1
    } state_t;

    state_t                 state_r;
    state_t                 state_next_s;
    logic [SYNC_STAGES-1:0] sync_r;
    logic                   ready_sync_s;
    logic [WIDTH_IN-1:0]    word_r;
    logic [IDX_W-1:0]       lane_idx_r;
    logic [IDX_W-1:0]       next_idx_s;
    logic [WIDTH_OUT-1:0]   out_data_r;
    logic                   out_valid_r;
    logic                   out_last_r;
    logic                   accepted_r;
    logic                   take_s;
    logic                   buf_free_s;
    logic                   capture_s;
    logic [WIDTH_OUT-1:0]   in_lane0_s;
    logic [WIDTH_OUT-1:0]   word_lanes_s [LANES];

`ifdef HS_RX_MSB_FIRST_EN
    assign in_lane0_s = data_in[WIDTH_IN-1 -: WIDTH_OUT];
    for (genvar k = 0; k < LANES; k++) begin : g_lanes
        assign word_lanes_s[k] = word_r[WIDTH_IN-1-k*WIDTH_OUT -: WIDTH_OUT];
    end
`else
    assign in_lane0_s = data_in[WIDTH_OUT-1:0];
    for (genvar k = 0; k < LANES; k++) begin : g_lanes
        assign word_lanes_s[k] = word_r[k*WIDTH_OUT +: WIDTH_OUT];
    end
`endif

    assign ready_sync_s = sync_r[SYNC_STAGES-1];
    assign take_s       = out_valid_r & out_ready;
    // A word may be captured on the same edge that drains the final lane, so back-to-back words have no bubble.
    assign buf_free_s   = ~out_valid_r | (take_s & out_last_r);
    assign capture_s    = (state_r == ST_IDLE) && (state_next_s == ST_ACK);
    assign next_idx_s   = lane_idx_r + 1'b1;

    // Synchroniser for the asynchronous ready_in.
    always_ff @(posedge clk) begin
        if (!rst) begin
            sync_r <= '0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], ready_in};
        end
    end

    // Handshake next-state decode.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ready_sync_s && buf_free_s) state_next_s = ST_ACK;
                else                            state_next_s = ST_IDLE;
            end
            ST_ACK: begin
                if (!ready_sync_s) state_next_s = ST_IDLE;
                else               state_next_s = ST_ACK;
            end
            default: state_next_s = ST_IDLE;
        endcase
    end

    // Handshake state and registered acknowledge.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r    <= ST_IDLE;
            accepted_r <= 1'b0;
        end else begin
            state_r    <= state_next_s;
            accepted_r <= (state_next_s == ST_ACK);
        end
    end

    // Capture buffer and lane sequencer.
    always_ff @(posedge clk) begin
        if (!rst) begin
            word_r      <= '0;
            lane_idx_r  <= '0;
            out_data_r  <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
        end else if (capture_s) begin
            word_r      <= data_in;
            lane_idx_r  <= '0;
            out_data_r  <= in_lane0_s;
            out_valid_r <= 1'b1;
            out_last_r  <= 1'b0;
        end else if (take_s) begin
            if (out_last_r) begin
                out_valid_r <= 1'b0;
                out_last_r  <= 1'b0;
            end else begin
                lane_idx_r  <= next_idx_s;
                out_data_r  <= word_lanes_s[next_idx_s];
                out_last_r  <= (next_idx_s == LAST_IDX);
            end
        end
    end

    assign accepted  = accepted_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign busy      = (state_r != ST_IDLE) || out_valid_r;

endmodule
